quad_decoder: RTL

//  x4 quadrature decoder; consumes the A/B pair from the quadrature square-wave generator
//  or an external encoder. Synchronises and glitch-filters A/B, then decodes each Gray step.

---
 rtl/quad_pkg.sv | 40 ++++
 rtl/quad_decoder_if.sv | 28 ++
 rtl/quad_input_filter.sv | 62 ++++++
 rtl/quad_decoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: shared types and constants for the x4 quadrature decoder.
//   trans_e     - classification of one filtered AB sample against the previous one
//   state_e     - decoder FSM encoding (INIT while the input pipeline settles, TRACK after)
//   AB_*        - Gray code positions of the forward sequence 10 -> 11 -> 01 -> 00 -> 10
//   TRANS_TBL   - 4x4 transition table indexed [prev_ab][cur_ab]
//   decode_step - table lookup helper
package quad_pkg;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_INC  = 2'd1,
    TR_DEC  = 2'd2,
    TR_ILL  = 2'd3
  } trans_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [1:0] AB_S0 = 2'b10;
  localparam logic [1:0] AB_S1 = 2'b11;
  localparam logic [1:0] AB_S2 = 2'b01;
  localparam logic [1:0] AB_S3 = 2'b00;

  // Rows are the previous AB value (0..3), columns the current AB value (0..3).
  // Forward neighbours (A leads B) increment, reverse neighbours decrement,
  // and the diagonal-opposite code (both bits changed) is illegal.
  localparam trans_e TRANS_TBL [4][4] = '{
    '{TR_NONE, TR_DEC,  TR_INC,  TR_ILL },  // prev 00
    '{TR_INC,  TR_NONE, TR_ILL,  TR_DEC },  // prev 01
    '{TR_DEC,  TR_ILL,  TR_NONE, TR_INC },  // prev 10
    '{TR_ILL,  TR_INC,  TR_DEC,  TR_NONE}   // prev 11
  };

  function automatic trans_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    return TRANS_TBL[prev_ab][cur_ab];
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: bundles the encoder phases, controls and decoder results.
//   quad_a, quad_b    - asynchronous encoder phases
//   en, clr, err_clr  - count enable, synchronous count clear, synchronous err clear
//   count, dir, step, err - signed position, last direction, step strobe, sticky error
// master drives phases/controls; slave (the decoder) drives the results.
interface quad_decoder_if #(
  parameter int CNT_W = 16
);
  logic             quad_a;
  logic             quad_b;
  logic             en;
  logic             clr;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output quad_a, quad_b, en, clr, err_clr,
    input  count, dir, step, err
  );

  modport slave (
    input  quad_a, quad_b, en, clr, err_clr,
    output count, dir, step, err
  );
endinterface

// File: rtl/quad_input_filter.sv
// quad_input_filter: synchroniser plus glitch filter for one quadrature phase.
//   clk, reset - clock and asynchronous active-high reset
//   raw_i      - asynchronous phase input
//   filt_o     - synchronised level, changed only after FILT_LEN consecutive
//                synced samples differing from the current filtered level
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Synchroniser shift chain; the oldest bit is the metastability-safe sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Filter next state: count differing samples, flip the level on the FILT_LEN-th.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = synced;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with filtered inputs.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - slave side of quad_decoder_if (phases/controls in, results out)
// A clean input edge reaches count/step after SYNC_STAGES+FILT_LEN+1 clock edges.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic           clk,
  input  logic           reset,
  quad_decoder_if.slave  bus
);

  // The filters come out of reset at 0, so the filtered AB only reflects the
  // real input level SETTLE cycles after release. INIT keeps re-loading
  // prev_ab until then, so the level present at release is never decoded as
  // a step or an illegal jump.
  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int SW     = $clog2(SETTLE + 1);

  logic             filt_a, filt_b;
  logic [1:0]       filt_ab;
  trans_e           trans_s;
  state_e           state_q, state_d;
  logic [SW-1:0]    init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d, count_step;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             ill_s;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .raw_i(bus.quad_a), .filt_o(filt_a)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .raw_i(bus.quad_b), .filt_o(filt_b)
  );

  assign filt_ab = {filt_a, filt_b};
  assign trans_s = decode_step(prev_q, filt_ab);

  // FSM next state, transition decode and counter update.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = filt_ab;
    count_step = count_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    ill_s      = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == SW'(SETTLE)) begin
          state_d = ST_TRACK;
        end else begin
          init_cnt_d = init_cnt_q + SW'(1);
        end
      end
      ST_TRACK: begin
        case (trans_s)
          TR_INC: begin
            if (bus.en) begin
              count_step = count_q + CNT_W'(1);
              dir_d      = 1'b1;
              step_d     = 1'b1;
            end else begin
              count_step = count_q;
            end
          end
          TR_DEC: begin
            if (bus.en) begin
              count_step = count_q - CNT_W'(1);
              dir_d      = 1'b0;
              step_d     = 1'b1;
            end else begin
              count_step = count_q;
            end
          end
          TR_ILL:  ill_s = 1'b1;
          default: ill_s = 1'b0;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
    // clr wins over a same-cycle step on the count only; step/dir still report it.
    count_d = bus.clr ? '0 : count_step;
    // A new illegal jump wins over a same-cycle err_clr.
    err_d   = (err_q & ~bus.err_clr) | ill_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      count_q    <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule
